v810_cache_fill: RTL and testbench

//  Line-fill engine directly upstream of the cache data RAM. On a cache miss it

---
 rtl/v810_cache_pkg.sv | 40 ++++
 rtl/v810_cache_fill_if.sv | 52 +++++
 rtl/v810_fill_seq.sv | 75 +++++++
 rtl/v810_cache_fill.sv | 239 +++++++++++++++++++++++
 tb/tb_v810_cache_fill.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/v810_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : v810_cache_pkg
// Purpose  : Shared geometry, fill-state encoding and address helper for the
//            v810 line-fill engine.
// Contents : ADDR_WIDTH/DATA_WIDTH/INDEX_WIDTH/WORD_WIDTH line geometry,
//            derived TAG/RAM-address/byte-offset widths, fill_state_t,
//            addr_fields_t and split_addr().
// Revision : 1.0  initial release
// ============================================================================
package v810_cache_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int INDEX_WIDTH    = 7;
    localparam int WORD_WIDTH     = 1;
    localparam int BYTE_OFF_WIDTH = $clog2(DATA_WIDTH / 8);
    localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - WORD_WIDTH - BYTE_OFF_WIDTH;
    localparam int RAM_ADDR_WIDTH = INDEX_WIDTH + WORD_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INVAL  = 2'd1,
        ST_FETCH  = 2'd2,
        ST_COMMIT = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]   tag;
        logic [INDEX_WIDTH-1:0] index;
        logic [WORD_WIDTH-1:0]  word;
    } addr_fields_t;

    // Takes the word address (byte offset already stripped) and splits it.
    function automatic addr_fields_t split_addr(input logic [ADDR_WIDTH-1:BYTE_OFF_WIDTH] word_addr);
        split_addr = word_addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/v810_cache_fill_if.sv
`default_nettype none
// ============================================================================
// Module   : v810_cache_fill_if
// Purpose  : Bundles the miss-request, bus-read, data-RAM write, tag write and
//            critical-word forward signals of the line-fill engine.
// Modports : master - the fill engine (drives req_ready, done, err, bus_req,
//                     bus_addr, dram_*, tag_*, fwd_*)
//            slave  - the surrounding cache/bus environment
// Revision : 1.0  initial release
// ============================================================================
interface v810_cache_fill_if;
    import v810_cache_pkg::*;

    logic                      req;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      req_ready;
    logic                      cancel;
    logic                      done;
    logic                      err;
    logic                      bus_req;
    logic [ADDR_WIDTH-1:0]     bus_addr;
    logic                      bus_ack;
    logic                      bus_err;
    logic [DATA_WIDTH-1:0]     bus_rdata;
    logic                      dram_wr_en;
    logic [RAM_ADDR_WIDTH-1:0] dram_wr_address;
    logic [DATA_WIDTH-1:0]     dram_wr_data;
    logic                      tag_wr_en;
    logic [INDEX_WIDTH-1:0]    tag_wr_index;
    logic [TAG_WIDTH-1:0]      tag_wr_tag;
    logic                      tag_wr_valid;
    logic                      fwd_valid;
    logic [DATA_WIDTH-1:0]     fwd_data;

    modport master (
        input  req, req_addr, cancel, bus_ack, bus_err, bus_rdata,
        output req_ready, done, err, bus_req, bus_addr,
               dram_wr_en, dram_wr_address, dram_wr_data,
               tag_wr_en, tag_wr_index, tag_wr_tag, tag_wr_valid,
               fwd_valid, fwd_data
    );

    modport slave (
        output req, req_addr, cancel, bus_ack, bus_err, bus_rdata,
        input  req_ready, done, err, bus_req, bus_addr,
               dram_wr_en, dram_wr_address, dram_wr_data,
               tag_wr_en, tag_wr_index, tag_wr_tag, tag_wr_valid,
               fwd_valid, fwd_data
    );

endinterface
`default_nettype wire

// File: rtl/v810_fill_seq.sv
`default_nettype none
// ============================================================================
// Module   : v810_fill_seq
// Purpose  : Beat sequencer for a line fill. Counts beats 0..N-1 and maps the
//            beat number to the word being fetched.
// Macro    : V810_CACHE_FILL_CWF_EN - word order starts at start_word and
//            wraps; otherwise words run 0..N-1 and start_word is ignored.
// Ports    : clock, reset_n    - clock / async active-low reset
//            load, start_word  - begin a new line at the given start word
//            advance           - current beat finished
//            cur_word          - word index of the current beat
//            first_beat        - current beat is beat 0
//            last_beat         - current beat is beat N-1
// Revision : 1.0  initial release
// ============================================================================
module v810_fill_seq
    import v810_cache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic [WORD_WIDTH-1:0] start_word,
    output logic [WORD_WIDTH-1:0] cur_word,
    output logic                  first_beat,
    output logic                  last_beat
);

    logic [WORD_WIDTH-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (load) begin
            beat_d = '0;
        end else if (advance) begin
            beat_d = beat_q + WORD_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign first_beat = (beat_q == '0);
    assign last_beat  = &beat_q;

`ifdef V810_CACHE_FILL_CWF_EN
    logic [WORD_WIDTH-1:0] start_q, start_d;

    always_comb begin
        start_d = load ? start_word : start_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= '0;
        end else begin
            start_q <= start_d;
        end
    end

    // Modular add gives the wrap w, w+1, ..., N-1, 0, ..., w-1.
    assign cur_word = start_q + beat_q;
`else
    logic unused_start;
    assign unused_start = ^start_word;
    assign cur_word     = beat_q;
`endif

endmodule
`default_nettype wire

// File: rtl/v810_cache_fill.sv
`default_nettype none
// ============================================================================
// Module   : v810_cache_fill
// Purpose  : Cache line-fill engine. On a miss it invalidates the line's tag,
//            reads every word of the line from the bus into the data RAM and
//            then writes the tag back as valid.
// Macro    : V810_CACHE_FILL_CWF_EN - critical word first with a forward of
//            the first word on fwd_valid/fwd_data; otherwise fwd_* are 0.
// Ports    : clock   - sole clock, rising edge
//            reset_n - asynchronous active-low reset
//            fill_if - master side of v810_cache_fill_if (request, bus read,
//                      data RAM write, tag write, forward)
// Revision : 1.0  initial release
// ============================================================================
module v810_cache_fill
    import v810_cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    v810_cache_fill_if.master fill_if
);

    fill_state_t               state_q, state_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic [INDEX_WIDTH-1:0]    index_q, index_d;
    logic                      cancel_pend_q, cancel_pend_d;
    logic                      fin_q, fin_d;
    logic                      bus_req_q, bus_req_d;
    logic [ADDR_WIDTH-1:0]     bus_addr_q, bus_addr_d;
    logic                      dram_wr_en_q, dram_wr_en_d;
    logic [RAM_ADDR_WIDTH-1:0] dram_wr_address_q, dram_wr_address_d;
    logic [DATA_WIDTH-1:0]     dram_wr_data_q, dram_wr_data_d;
    logic                      tag_wr_en_q, tag_wr_en_d;
    logic [INDEX_WIDTH-1:0]    tag_wr_index_q, tag_wr_index_d;
    logic [TAG_WIDTH-1:0]      tag_wr_tag_q, tag_wr_tag_d;
    logic                      tag_wr_valid_q, tag_wr_valid_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    addr_fields_t              req_fields;
    logic [WORD_WIDTH-1:0]     cur_word;
    logic                      seq_load;
    logic                      seq_first;
    logic                      seq_last;
    logic                      beat_ack;
    logic                      unused_byte_off;

    assign req_fields      = split_addr(fill_if.req_addr[ADDR_WIDTH-1:BYTE_OFF_WIDTH]);
    assign unused_byte_off = ^fill_if.req_addr[BYTE_OFF_WIDTH-1:0];
    assign seq_load        = (state_q == ST_IDLE) && fill_if.req;
    // Only an ack to an outstanding request completes a beat.
    assign beat_ack        = (state_q == ST_FETCH) && bus_req_q && fill_if.bus_ack;

    v810_fill_seq u_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (seq_load),
        .advance    (beat_ack),
        .start_word (req_fields.word),
        .cur_word   (cur_word),
        .first_beat (seq_first),
        .last_beat  (seq_last)
    );

    always_comb begin
        state_d           = state_q;
        tag_d             = tag_q;
        index_d           = index_q;
        cancel_pend_d     = cancel_pend_q;
        fin_d             = fin_q;
        bus_req_d         = bus_req_q;
        bus_addr_d        = bus_addr_q;
        dram_wr_en_d      = 1'b0;
        dram_wr_address_d = dram_wr_address_q;
        dram_wr_data_d    = dram_wr_data_q;
        tag_wr_en_d       = 1'b0;
        tag_wr_index_d    = tag_wr_index_q;
        tag_wr_tag_d      = tag_wr_tag_q;
        tag_wr_valid_d    = tag_wr_valid_q;
        done_d            = 1'b0;
        err_d             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fill_if.req) begin
                    tag_d          = req_fields.tag;
                    index_d        = req_fields.index;
                    cancel_pend_d  = 1'b0;
                    fin_d          = 1'b0;
                    // Tag invalidate is presented during the INVAL cycle.
                    tag_wr_en_d    = 1'b1;
                    tag_wr_index_d = req_fields.index;
                    tag_wr_tag_d   = req_fields.tag;
                    tag_wr_valid_d = 1'b0;
                    state_d        = ST_INVAL;
                end
            end

            ST_INVAL: begin
                if (fill_if.cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    bus_req_d  = 1'b1;
                    bus_addr_d = {tag_q, index_q, cur_word, {BYTE_OFF_WIDTH{1'b0}}};
                    state_d    = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (bus_req_q) begin
                    if (fill_if.bus_ack) begin
                        bus_req_d         = 1'b0;
                        dram_wr_en_d      = 1'b1;
                        dram_wr_address_d = {index_q, cur_word};
                        dram_wr_data_d    = fill_if.bus_rdata;
                        if (fill_if.cancel || cancel_pend_q) begin
                            state_d = ST_IDLE;
                        end else if (seq_last) begin
                            fin_d = 1'b1;
                        end
                    end else if (fill_if.bus_err) begin
                        bus_req_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (fill_if.cancel) begin
                        // The open request must still be answered first.
                        cancel_pend_d = 1'b1;
                    end
                end else begin
                    // Gap cycle after an ack: the RAM write is on the port now,
                    // so the tag commit lands one cycle later, never together.
                    if (fill_if.cancel) begin
                        state_d = ST_IDLE;
                    end else if (fin_q) begin
                        tag_wr_en_d    = 1'b1;
                        tag_wr_index_d = index_q;
                        tag_wr_tag_d   = tag_q;
                        tag_wr_valid_d = 1'b1;
                        done_d         = 1'b1;
                        state_d        = ST_COMMIT;
                    end else begin
                        bus_req_d  = 1'b1;
                        bus_addr_d = {tag_q, index_q, cur_word, {BYTE_OFF_WIDTH{1'b0}}};
                    end
                end
            end

            ST_COMMIT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            tag_q             <= '0;
            index_q           <= '0;
            cancel_pend_q     <= 1'b0;
            fin_q             <= 1'b0;
            bus_req_q         <= 1'b0;
            bus_addr_q        <= '0;
            dram_wr_en_q      <= 1'b0;
            dram_wr_address_q <= '0;
            dram_wr_data_q    <= '0;
            tag_wr_en_q       <= 1'b0;
            tag_wr_index_q    <= '0;
            tag_wr_tag_q      <= '0;
            tag_wr_valid_q    <= 1'b0;
            done_q            <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            tag_q             <= tag_d;
            index_q           <= index_d;
            cancel_pend_q     <= cancel_pend_d;
            fin_q             <= fin_d;
            bus_req_q         <= bus_req_d;
            bus_addr_q        <= bus_addr_d;
            dram_wr_en_q      <= dram_wr_en_d;
            dram_wr_address_q <= dram_wr_address_d;
            dram_wr_data_q    <= dram_wr_data_d;
            tag_wr_en_q       <= tag_wr_en_d;
            tag_wr_index_q    <= tag_wr_index_d;
            tag_wr_tag_q      <= tag_wr_tag_d;
            tag_wr_valid_q    <= tag_wr_valid_d;
            done_q            <= done_d;
            err_q             <= err_d;
        end
    end

`ifdef V810_CACHE_FILL_CWF_EN
    logic                  fwd_valid_q, fwd_valid_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    // Beat 0 is the requested (critical) word; forward it with its RAM write.
    always_comb begin
        fwd_valid_d = beat_ack && seq_first && !fill_if.bus_err;
        fwd_data_d  = fwd_valid_d ? fill_if.bus_rdata : fwd_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign fill_if.fwd_valid = fwd_valid_q;
    assign fill_if.fwd_data  = fwd_data_q;
`else
    logic unused_first;
    assign unused_first      = seq_first;
    assign fill_if.fwd_valid = 1'b0;
    assign fill_if.fwd_data  = '0;
`endif

    assign fill_if.req_ready       = (state_q == ST_IDLE);
    assign fill_if.bus_req         = bus_req_q;
    assign fill_if.bus_addr        = bus_addr_q;
    assign fill_if.dram_wr_en      = dram_wr_en_q;
    assign fill_if.dram_wr_address = dram_wr_address_q;
    assign fill_if.dram_wr_data    = dram_wr_data_q;
    assign fill_if.tag_wr_en       = tag_wr_en_q;
    assign fill_if.tag_wr_index    = tag_wr_index_q;
    assign fill_if.tag_wr_tag      = tag_wr_tag_q;
    assign fill_if.tag_wr_valid    = tag_wr_valid_q;
    assign fill_if.done            = done_q;
    assign fill_if.err             = err_q;

endmodule
`default_nettype wire

// File: tb/tb_v810_cache_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_v810_cache_fill
// Purpose  : Self-checking bench for v810_cache_fill. Directed fills plus
//            randomized fills (address, ack latency, cancel, bus error), each
//            compared against a line-level model of the fill.
// Macro    : V810_CACHE_FILL_CWF_EN selects the expected word order/forward.
// Revision : 1.0  initial release
// ============================================================================
module tb_v810_cache_fill;
    import v810_cache_pkg::*;

`ifdef V810_CACHE_FILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    localparam int N_WORDS = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    v810_cache_fill_if fill_if ();

    v810_cache_fill dut (
        .clock   (clock),
        .reset_n (reset_n),
        .fill_if (fill_if.master)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] salt;

    // Observed activity, logged on the falling edge.
    logic [39:0] dram_log[$];   // {ram address, data}
    logic [29:0] tag_log[$];    // {valid, index, tag}
    logic [40:0] fwd_log[$];    // {dram_wr_en, ram address, fwd_data}
    int          n_done;
    int          n_err;
    logic        prev_bus_req;
    logic [31:0] prev_bus_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_bus_req = 1'b0;
        end else begin
            if (fill_if.dram_wr_en) dram_log.push_back({fill_if.dram_wr_address, fill_if.dram_wr_data});
            if (fill_if.tag_wr_en)  tag_log.push_back({fill_if.tag_wr_valid, fill_if.tag_wr_index, fill_if.tag_wr_tag});
            if (fill_if.fwd_valid)  fwd_log.push_back({fill_if.dram_wr_en, fill_if.dram_wr_address, fill_if.fwd_data});
            if (fill_if.done) n_done++;
            if (fill_if.err)  n_err++;
            if (fill_if.dram_wr_en || fill_if.tag_wr_en)
                check("dram_tag_same_cycle", {63'd0, fill_if.dram_wr_en & fill_if.tag_wr_en}, 64'd0);
            if (prev_bus_req && fill_if.bus_req)
                check("bus_addr_stable", {32'd0, fill_if.bus_addr}, {32'd0, prev_bus_addr});
            prev_bus_req  = fill_if.bus_req;
            prev_bus_addr = fill_if.bus_addr;
        end
    end

    // One request from an idle engine, with a bus responder. cancel_beat /
    // err_beat of -1 disable that event; cancel_early pulses cancel while the
    // beat's request is still unanswered instead of with its ack.
    task automatic do_fill(input logic [31:0] addr, input int cancel_beat, input bit cancel_early,
                           input int err_beat, input int dly_lo, input int dly_hi, input bit hold_req);
        logic [31:0] got_addr[$];
        logic [31:0] exp_addr[$];
        logic [39:0] exp_dram[$];
        logic [29:0] exp_tag[$];
        int          beat = 0;
        int          dly  = 0;
        bit          busy = 1'b0;
        bit          finished = 1'b0;
        bit          complete = 1'b1;
        bit          errd = 1'b0;
        int          start_w;
        int          w;
        logic [31:0] ba;
        logic [6:0]  idx;
        logic [21:0] tg;

        dram_log.delete(); tag_log.delete(); fwd_log.delete();
        n_done = 0; n_err = 0;
        fill_if.req      = 1'b1;
        fill_if.req_addr = addr;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clock);
            fill_if.bus_ack = 1'b0;
            fill_if.bus_err = 1'b0;
            fill_if.cancel  = 1'b0;
            if (!hold_req || fill_if.done) fill_if.req = 1'b0;
            if (fill_if.req_ready) begin
                finished = 1'b1;
            end else if (fill_if.bus_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    dly  = $urandom_range(dly_hi, dly_lo);
                    if (beat == cancel_beat && cancel_early) begin
                        if (dly == 0) dly = 1;
                        fill_if.cancel = 1'b1;
                    end
                end
                if (dly == 0) begin
                    got_addr.push_back(fill_if.bus_addr);
                    if (beat == err_beat) begin
                        fill_if.bus_err = 1'b1;
                    end else begin
                        fill_if.bus_ack   = 1'b1;
                        fill_if.bus_rdata = mem_word(fill_if.bus_addr);
                    end
                    if (beat == cancel_beat && !cancel_early) fill_if.cancel = 1'b1;
                    busy = 1'b0;
                    beat++;
                end else begin
                    dly--;
                end
            end
        end
        fill_if.req = 1'b0;
        check("fill_finished", {63'd0, finished}, 64'd1);
        @(negedge clock);
        check("ready_after_fill", {63'd0, fill_if.req_ready}, 64'd1);

        // Line-level model of the fill.
        idx     = 7'((addr / 8) % 128);
        tg      = 22'(addr / 1024);
        start_w = CWF ? int'((addr / 4) % N_WORDS) : 0;
        for (int k = 0; k < N_WORDS; k++) begin
            w  = (start_w + k) % N_WORDS;
            ba = (addr / 8) * 8 + 32'(w * 4);
            exp_addr.push_back(ba);
            if (k == err_beat) begin
                errd = 1'b1; complete = 1'b0;
                break;
            end
            exp_dram.push_back({8'(int'(idx) * N_WORDS + w), mem_word(ba)});
            if (k == cancel_beat) begin
                complete = 1'b0;
                break;
            end
        end
        exp_tag.push_back({1'b0, idx, tg});
        if (complete) exp_tag.push_back({1'b1, idx, tg});

        check("bus_beats", 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            check("bus_addr", {32'd0, got_addr[i]}, {32'd0, exp_addr[i]});
        check("dram_writes", 64'(dram_log.size()), 64'(exp_dram.size()));
        for (int i = 0; i < dram_log.size() && i < exp_dram.size(); i++)
            check("dram_write", {24'd0, dram_log[i]}, {24'd0, exp_dram[i]});
        check("tag_writes", 64'(tag_log.size()), 64'(exp_tag.size()));
        for (int i = 0; i < tag_log.size() && i < exp_tag.size(); i++)
            check("tag_write", {34'd0, tag_log[i]}, {34'd0, exp_tag[i]});
        check("done_pulses", 64'(n_done), 64'(complete));
        check("err_pulses", 64'(n_err), 64'(errd));
        if (CWF && exp_dram.size() > 0) begin
            check("fwd_pulses", 64'(fwd_log.size()), 64'd1);
            if (fwd_log.size() > 0) check("fwd_word", {23'd0, fwd_log[0]}, {23'd0, 1'b1, exp_dram[0]});
        end else begin
            check("fwd_pulses", 64'(fwd_log.size()), 64'd0);
        end
    endtask

    initial begin
        salt              = $urandom;
        fill_if.req       = 1'b0;
        fill_if.req_addr  = '0;
        fill_if.cancel    = 1'b0;
        fill_if.bus_ack   = 1'b0;
        fill_if.bus_err   = 1'b0;
        fill_if.bus_rdata = '0;

        repeat (3) @(negedge clock);
        check("reset_req_ready", {63'd0, fill_if.req_ready}, 64'd1);
        check("reset_outputs", {58'd0, fill_if.bus_req, fill_if.dram_wr_en, fill_if.tag_wr_en,
                                fill_if.tag_wr_valid, fill_if.done, fill_if.err}, 64'd0);
        check("reset_bus_addr", {32'd0, fill_if.bus_addr}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_req_ready", {63'd0, fill_if.req_ready}, 64'd1);

        // Plain fill of line 0x25.
        do_fill(32'h0000_0128, -1, 1'b0, -1, 0, 0, 1'b0);
        // Request on word 1 (critical word first when enabled).
        do_fill(32'h0000_012C, -1, 1'b0, -1, 0, 1, 1'b0);
        // cancel coincident with beat-0 ack.
        do_fill(32'h1234_5678, 0, 1'b0, -1, 0, 2, 1'b0);
        // bus error on beat 1.
        do_fill(32'hCAFE_0128, -1, 1'b0, 1, 1, 2, 1'b0);
        // cancel while beat 1 is still unanswered.
        do_fill(32'h0BAD_F00C, 1, 1'b1, -1, 1, 3, 1'b0);

        // Asynchronous reset in the middle of a fetch.
        fill_if.req      = 1'b1;
        fill_if.req_addr = 32'h0000_3A40;
        @(negedge clock);
        fill_if.req = 1'b0;
        for (int k = 0; k < 20 && !fill_if.bus_req; k++) @(negedge clock);
        check("rst_reached_fetch", {63'd0, fill_if.bus_req}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_outputs", {58'd0, fill_if.bus_req, fill_if.dram_wr_en, fill_if.tag_wr_en,
                                    fill_if.tag_wr_valid, fill_if.done, fill_if.err}, 64'd0);
        check("rst_async_bus_addr", {32'd0, fill_if.bus_addr}, 64'd0);
        check("rst_async_ready", {63'd0, fill_if.req_ready}, 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_fill(32'h0000_3A44, -1, 1'b0, -1, 0, 2, 1'b0);

        // req held through the fill, each ack 5 cycles late.
        do_fill(32'h0000_0F04, -1, 1'b0, -1, 5, 5, 1'b1);

        for (int i = 0; i < 24; i++) begin
            int cb;
            int eb;
            bit ce;
            int mode;
            cb   = -1;
            eb   = -1;
            ce   = 1'b0;
            mode = int'($urandom_range(3, 0));
            if (mode == 1) begin
                cb = int'($urandom_range(1, 0));
                ce = 1'($urandom_range(1, 0));
            end else if (mode == 2) begin
                eb = int'($urandom_range(1, 0));
            end
            do_fill($urandom, cb, ce, eb, 0, 3, 1'($urandom_range(1, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
